// File: rtl/ball_centroid_tracker.sv
// Bright-pixel centroid tracker for the D8M pixel stream: per-frame coordinate sums, then a
// bit-serial restoring divide at frame end. Define BBOX_EN to add bounding-box outputs.
module ball_centroid_tracker #(
    parameter int DATA_W     = 12,
    parameter int X_W        = 11,
    parameter int Y_W        = 11,
    parameter int MIN_PIXELS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pix_d,
    input  logic              pix_fval,
    input  logic              pix_lval,
    input  logic              enable,
    input  logic [DATA_W-1:0] threshold,
    output logic [X_W-1:0]    ball_x,
    output logic [Y_W-1:0]    ball_y,
    output logic              ball_found,
    output logic              result_valid,
    output logic [15:0]       frame_count,
    output logic              frame_dropped,
`ifdef BBOX_EN
    output logic [X_W-1:0]    bbox_xmin,
    output logic [X_W-1:0]    bbox_xmax,
    output logic [Y_W-1:0]    bbox_ymin,
    output logic [Y_W-1:0]    bbox_ymax,
`endif
    output logic              busy
);

    localparam int ITER  = (X_W > Y_W) ? X_W : Y_W;
    localparam int CNT_W = X_W + Y_W;
    localparam int SX_W  = 2 * X_W + Y_W;
    localparam int SY_W  = X_W + 2 * Y_W;
    localparam int DIV_W = CNT_W + ITER;
    localparam int IT_W  = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

    function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
        return (&v) ? v : v + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
        return (&v) ? v : v + Y_W'(1);
    endfunction

    // One restoring step: returns {quotient bit, new remainder}.
    function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                                input logic              msb,
                                                input logic [CNT_W-1:0] d);
        logic [CNT_W:0] trial;
        logic           q;
        trial = {rem, msb};
        q     = (trial >= {1'b0, d});
        return {q, trial[CNT_W-1:0] - (q ? d : CNT_W'(0))};
    endfunction

    logic [DATA_W-1:0] pix_d_p0;
    logic              fval_p0, fval_p1, lval_p0, lval_p1;
    logic              armed, en_lat;
    logic [DATA_W-1:0] thr_lat;
    logic [X_W-1:0]    x_pos;
    logic [Y_W-1:0]    y_pos;
    logic [SX_W-1:0]   sum_x;
    logic [SY_W-1:0]   sum_y;
    logic [CNT_W-1:0]  cnt;
    logic              frame_start, frame_end, line_end, pix_vld, bright;

    state_t            state, state_nxt;
    logic              div_load, drop, out_cyc;
    logic [IT_W-1:0]   it_cnt;
    logic [CNT_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  rem_x, rem_y;
    logic [ITER-1:0]   low_x, low_y;
    logic [CNT_W:0]    step_x, step_y;
    logic              found;

`ifdef BBOX_EN
    logic [X_W-1:0]    acc_xmin, acc_xmax, div_xmin, div_xmax;
    logic [Y_W-1:0]    acc_ymin, acc_ymax, div_ymin, div_ymax;
`endif

    // Input stage p0, edge-detect copy p1. fval resets high so that a reset released
    // mid-frame cannot fake a frame start; the next real rising edge is required.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_d_p0 <= '0;
            fval_p0  <= 1'b1;
            fval_p1  <= 1'b1;
            lval_p0  <= 1'b0;
            lval_p1  <= 1'b0;
        end else begin
            pix_d_p0 <= pix_d;
            fval_p0  <= pix_fval;
            lval_p0  <= pix_lval;
            fval_p1  <= fval_p0;
            lval_p1  <= lval_p0;
        end
    end

    assign frame_start = fval_p0 & ~fval_p1;
    assign frame_end   = ~fval_p0 & fval_p1 & armed & en_lat;
    assign line_end    = armed & fval_p1 & lval_p1 & (~lval_p0 | ~fval_p0);
    assign pix_vld     = fval_p0 & lval_p0 & armed & en_lat;
    assign bright      = pix_d_p0 >= thr_lat;

    // Accumulation stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed   <= 1'b0;
            en_lat  <= 1'b0;
            thr_lat <= '0;
            x_pos   <= '0;
            y_pos   <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
            cnt     <= '0;
`ifdef BBOX_EN
            acc_xmin <= '0;
            acc_xmax <= '0;
            acc_ymin <= '0;
            acc_ymax <= '0;
`endif
        end else if (frame_start) begin
            armed   <= 1'b1;
            en_lat  <= enable;
            thr_lat <= threshold;
            x_pos   <= '0;
            y_pos   <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
            cnt     <= '0;
`ifdef BBOX_EN
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
`endif
        end else begin
            if (line_end) begin
                x_pos <= '0;
                y_pos <= sat_inc_y(y_pos);
            end else if (pix_vld) begin
                x_pos <= sat_inc_x(x_pos);
            end
            if (pix_vld && bright) begin
                sum_x <= sum_x + SX_W'(x_pos);
                sum_y <= sum_y + SY_W'(y_pos);
                cnt   <= cnt + CNT_W'(1);
`ifdef BBOX_EN
                if (x_pos < acc_xmin) acc_xmin <= x_pos;
                if (x_pos > acc_xmax) acc_xmax <= x_pos;
                if (y_pos < acc_ymin) acc_ymin <= y_pos;
                if (y_pos > acc_ymax) acc_ymax <= y_pos;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_end) state_nxt = S_DIV;
            S_DIV:   if (it_cnt == IT_W'(ITER - 1)) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        div_load = 1'b0;
        drop     = 1'b0;
        out_cyc  = 1'b0;
        case (state)
            S_IDLE: div_load = frame_end;
            S_DIV: begin
                busy = 1'b1;
                drop = frame_end;
            end
            S_OUT: begin
                busy    = 1'b1;
                drop    = frame_end;
                out_cyc = 1'b1;
            end
            default: ;
        endcase
    end

    assign step_x = div_step(rem_x, low_x[ITER-1], div_cnt);
    assign step_y = div_step(rem_y, low_y[ITER-1], div_cnt);
    assign found  = div_cnt >= CNT_W'(MIN_PIXELS);

    // Divide stage: low_* shifts the dividend out and the quotient in. The upper dividend
    // part is always below cnt because the quotient fits in ITER bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            it_cnt  <= '0;
            div_cnt <= '0;
            rem_x   <= '0;
            rem_y   <= '0;
            low_x   <= '0;
            low_y   <= '0;
`ifdef BBOX_EN
            div_xmin <= '0;
            div_xmax <= '0;
            div_ymin <= '0;
            div_ymax <= '0;
`endif
        end else if (div_load) begin
            it_cnt         <= '0;
            div_cnt        <= cnt;
            {rem_x, low_x} <= DIV_W'(sum_x);
            {rem_y, low_y} <= DIV_W'(sum_y);
`ifdef BBOX_EN
            div_xmin <= acc_xmin;
            div_xmax <= acc_xmax;
            div_ymin <= acc_ymin;
            div_ymax <= acc_ymax;
`endif
        end else if (state == S_DIV) begin
            it_cnt <= it_cnt + IT_W'(1);
            if (div_cnt != '0) begin
                rem_x <= step_x[CNT_W-1:0];
                low_x <= {low_x[ITER-2:0], step_x[CNT_W]};
                rem_y <= step_y[CNT_W-1:0];
                low_y <= {low_y[ITER-2:0], step_y[CNT_W]};
            end
        end
    end

    // Result stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_x        <= '0;
            ball_y        <= '0;
            ball_found    <= 1'b0;
            result_valid  <= 1'b0;
            frame_count   <= '0;
            frame_dropped <= 1'b0;
`ifdef BBOX_EN
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
`endif
        end else begin
            result_valid  <= out_cyc;
            frame_dropped <= drop;
            if (out_cyc) begin
                frame_count <= frame_count + 16'd1;
                ball_found  <= found;
                if (found) begin
                    ball_x <= low_x[X_W-1:0];
                    ball_y <= low_y[Y_W-1:0];
`ifdef BBOX_EN
                    bbox_xmin <= div_xmin;
                    bbox_xmax <= div_xmax;
                    bbox_ymin <= div_ymin;
                    bbox_ymax <= div_ymax;
`endif
                end
            end
        end
    end

endmodule

// File: doc/ball_centroid_tracker.md
Name: ball_centroid_tracker

Overview:
- Sits directly downstream of the D8M camera pixel interface (MIPI_PIXEL_D/HS/VS), in parallel with the camera capture path into the Qsys system.
- Thresholds each raw pixel and accumulates coordinate sums of bright pixels per frame.
- At frame end, computes the ball centroid with an iterative divider and presents it with a one-cycle valid pulse for the Nios II PIO and the VGA overlay logic.

Parameters:
- DATA_W, 12, pixel width; matches the padded {MIPI_PIXEL_D, 2'b00} bus.
- X_W, 11, column counter and ball_x width.
- Y_W, 11, row counter and ball_y width.
- MIN_PIXELS, 16, minimum bright-pixel count for ball_found=1.

Ports:
- clk  in  1  pixel clock (inverted MIPI_PIXEL_CLK domain); all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- pix_d  in  DATA_W  pixel data
- pix_fval  in  1  frame valid (MIPI_PIXEL_VS)
- pix_lval  in  1  line valid (MIPI_PIXEL_HS)
- enable  in  1  tracking enable, sampled at frame start
- threshold  in  DATA_W  brightness threshold, sampled at frame start
- ball_x  out  X_W  centroid column
- ball_y  out  Y_W  centroid row
- ball_found  out  1  last result had count >= MIN_PIXELS
- result_valid  out  1  one-cycle pulse when ball_x, ball_y, ball_found update
- frame_count  out  16  tracked frames completed, wraps at 0xFFFF->0
- frame_dropped  out  1  one-cycle pulse when a frame end arrives while the divider is busy
- busy  out  1  divider running

Behaviour:
- Reset: all outputs 0; accumulators, counters and FSM cleared; armed=0.
- Interface is fixed as decided: one clock `clk`, asynchronous active-low reset `reset_n`.
- Input stage:
  - pix_d, pix_fval and pix_lval are registered once.
  - Edges are detected between the registered value and its one-cycle-delayed copy.
- Frame start is a rising edge of registered fval.
  - Sets armed=1.
  - Clears sum_x, sum_y, cnt, x and y.
  - Latches enable and threshold into frame-local copies.
- If reset deasserts while fval=1, the block ignores everything until the next frame start.
- Pixel handling:
  - A pixel is valid when registered fval=1, lval=1, armed=1 and the latched enable=1.
  - x increments on every lval=1 cycle and saturates at 2^X_W-1.
  - A pixel is bright when pix_d >= the latched threshold (unsigned compare).
  - A bright pixel does sum_x += x, sum_y += y, cnt += 1.
- Line end is a falling edge of lval, or fval falling while lval=1.
  - x returns to 0.
  - y increments and saturates at 2^Y_W-1.
  - lval activity while fval=0 is ignored.
- Widths:
  - cnt is X_W+Y_W bits.
  - sum_x is 2*X_W+Y_W bits; sum_y is X_W+2*Y_W bits.
  - None of these can overflow.
- Frame end (cycle T0) is a falling edge of registered fval with armed=1 and the latched enable=1.
  - A frame whose latched enable=0 produces no result and is not counted.
- FSM states and transitions:
  - IDLE->DIV at T0: sums and cnt are copied into divider registers, so accumulation of the next frame may proceed concurrently. busy=1.
  - DIV: two restoring dividers run in parallel (sum_x/cnt, sum_y/cnt), one quotient bit per cycle, for ITER = max(X_W,Y_W) cycles. The quotient is the floor.
  - DIV->OUT after ITER cycles.
  - OUT: if cnt >= MIN_PIXELS, ball_x/ball_y take the quotients and ball_found=1. Otherwise ball_x/ball_y hold their previous values and ball_found=0. result_valid=1 and frame_count increments, all for this one cycle. OUT->IDLE; busy=0.
- Latency: result_valid asserts ITER+2 cycles after T0, independent of cnt.
- If cnt=0, division is skipped internally but the latency is unchanged.
- Frame end while busy=1: the frame is discarded, frame_dropped pulses for one cycle, and the in-progress division is unaffected.
- Frame start and frame end of different frames in the same cycle is impossible because they are fval edges of opposite polarity.

Optional Feature:
- Macro BBOX_EN.
- When defined:
  - Adds outputs bbox_xmin/bbox_xmax (X_W bits) and bbox_ymin/bbox_ymax (Y_W bits).
  - Min/max of bright-pixel coordinates are tracked per frame and reset to max/0 at frame start.
  - They are copied at T0 and updated in the OUT cycle only when ball_found=1.
  - Reset value is 0.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- 16x8 frame, threshold=0x800, 4x4 block of 0xFFF at x4..7/y2..5, rest 0 -> result_valid exactly 13 cycles after T0; ball_x=5, ball_y=3, ball_found=1, frame_count=1.
- Next frame all pixels 0x100 -> ball_found=0; ball_x=5, ball_y=3 held; frame_count=2.
- Second frame's fval falls 5 cycles after the first T0 -> frame_dropped pulses; first result still correct; frame_count increments once.
- enable=0 at frame start, toggled to 1 mid-frame -> no result_valid; frame_count unchanged.
- Assert reset_n mid-frame and release with fval=1 -> outputs 0 at once; first result comes only after a full subsequent frame.
- BBOX_EN defined, first scenario -> bbox_xmin=4, bbox_xmax=7, bbox_ymin=2, bbox_ymax=5.
